onchip_mem_arbiter: RTL

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter_if.sv | 52 +++++
 rtl/onchip_mem_arbiter.sv | 90 +++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle for the two-requester on-chip RAM arbiter: requester ports m0/m1 and the RAM command port.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface onchip_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters,
// with a one-entry command stage and a fixed two-cycle read-return path.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 reset_req,
  onchip_mem_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              owner;
  } cmd_t;

  cmd_t cmd_q;
  cmd_t cmd_d;
  logic cmd_valid_q;
  logic last_m1_q;
  logic rdv0_q;
  logic rdv1_q;
  logic req0;
  logic req1;
  logic grant0;
  logic grant1;

  // Grant selection: the master not served most recently wins a contention.
  always_comb begin
    req0   = bus.m0_read | bus.m0_write;
    req1   = bus.m1_read | bus.m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    cmd_d  = cmd_q;
    if (!reset && !reset_req) begin
      if (req0 && (!req1 || last_m1_q)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
    // Read+write together is a write; the payload holds when nothing is accepted.
    if (grant0) begin
      cmd_d = '{addr: bus.m0_address, be: bus.m0_byteenable, wdata: bus.m0_writedata,
                write: bus.m0_write, owner: 1'b0};
    end else if (grant1) begin
      cmd_d = '{addr: bus.m1_address, be: bus.m1_byteenable, wdata: bus.m1_writedata,
                write: bus.m1_write, owner: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      last_m1_q   <= 1'b1;
      rdv0_q      <= 1'b0;
      rdv1_q      <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= grant0 | grant1;
      if (grant0 | grant1) begin
        last_m1_q <= grant1;
      end
      // RAM returns data the cycle after it samples the command stage.
      rdv0_q <= cmd_valid_q & ~cmd_q.write & ~cmd_q.owner;
      rdv1_q <= cmd_valid_q & ~cmd_q.write & cmd_q.owner;
    end
  end

  assign bus.m0_waitrequest   = ~grant0;
  assign bus.m1_waitrequest   = ~grant1;
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = rdv0_q;
  assign bus.m1_readdatavalid = rdv1_q;

  assign bus.mem_address    = cmd_q.addr;
  assign bus.mem_byteenable = cmd_q.be;
  assign bus.mem_writedata  = cmd_q.wdata;
  assign bus.mem_chipselect = cmd_valid_q;
  assign bus.mem_write      = cmd_valid_q & cmd_q.write;
  // Clock enable drops only once a pending reset has drained the command stage.
  assign bus.mem_clken      = reset | ~(reset_req & ~cmd_valid_q);
endmodule
